// File: rtl/io_handshake_ctrl.sv
// Switch handshake controller: synchronises and debounces SW[8], stalls the PC
// during wait instructions and captures the switch operand on a wait-high grant.
module io_handshake_ctrl #(
    parameter int n         = 8,
    parameter int db_cycles = 4,
    parameter int cw        = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] sw_data,
    input  logic         sw_ready,
    input  logic         wait_req,
    input  logic         wait_level,
    output logic         stall,
    output logic         in_valid,
    output logic [n-1:0] in_data,
    output logic         ready_db
);

    localparam logic [cw-1:0] CNT_LAST = cw'(db_cycles - 1);
    localparam logic [cw-1:0] CNT_ZERO = {cw{1'b0}};
    localparam logic [cw-1:0] CNT_ONE  = cw'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    logic          s1_r;
    logic          ready_sync_r;
    logic          ready_db_r;
    logic [cw-1:0] count_r;
    logic [n-1:0]  in_data_r;
    state_t        state_r;
    state_t        next_state_s;
    logic          capture_s;

    // Two-flop synchroniser for the asynchronous handshake switch.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r         <= 1'b0;
            ready_sync_r <= 1'b0;
        end else begin
            s1_r         <= sw_ready;
            ready_sync_r <= s1_r;
        end
    end

    // Debounce: the level must differ for db_cycles consecutive edges to be accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_db_r <= 1'b0;
            count_r    <= CNT_ZERO;
        end else if (ready_sync_r == ready_db_r) begin
            count_r    <= CNT_ZERO;
        end else if (count_r == CNT_LAST) begin
            ready_db_r <= ready_sync_r;
            count_r    <= CNT_ZERO;
        end else begin
            count_r    <= count_r + CNT_ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; capture only happens on the WAIT->GRANT edge of a wait-high.
    always_comb begin
        next_state_s = ST_IDLE;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wait_req) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!wait_req) begin
                    next_state_s = ST_IDLE;
                end else if (ready_db_r == wait_level) begin
                    next_state_s = ST_GRANT;
                    capture_s    = wait_level;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_GRANT: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Captured operand register feeding the ALU switch input.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_data_r <= {n{1'b0}};
        end else if (capture_s) begin
            in_data_r <= sw_data;
        end else begin
            in_data_r <= in_data_r;
        end
    end

    // PC control: stall must drop in GRANT so the PC advances on the in_valid cycle.
    always_comb begin
        stall    = 1'b0;
        in_valid = 1'b0;
        if (state_r == ST_GRANT) begin
            in_valid = 1'b1;
            stall    = 1'b0;
        end else begin
            in_valid = 1'b0;
            stall    = wait_req;
        end
    end

    assign in_data  = in_data_r;
    assign ready_db = ready_db_r;

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Self-checking bench for io_handshake_ctrl: per-cycle vector table with
// hand-derived expectations, routed through a scoreboard queue.
module tb_io_handshake_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_data;
    logic       sw_ready;
    logic       wait_req;
    logic       wait_level;
    logic       stall;
    logic       in_valid;
    logic [7:0] in_data;
    logic       ready_db;

    always #5 clk = ~clk;

    io_handshake_ctrl #(
        .n(8),
        .db_cycles(4),
        .cw(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_data(sw_data),
        .sw_ready(sw_ready),
        .wait_req(wait_req),
        .wait_level(wait_level),
        .stall(stall),
        .in_valid(in_valid),
        .in_data(in_data),
        .ready_db(ready_db)
    );

    // exp packs {stall, in_valid, in_data, ready_db}
    typedef struct {
        string      name;
        logic       rst;
        logic [7:0] data;
        logic       rdy;
        logic       wr;
        logic       wl;
        int         reps;
        logic [10:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        int          cyc;
        logic [10:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    function automatic vec_t mk(string nm, logic r, logic [7:0] d, logic rdy, logic wr,
                                logic wl, int reps, logic st, logic vl, logic [7:0] ed,
                                logic rdb);
        vec_t v;
        v.name = nm;
        v.rst  = r;
        v.data = d;
        v.rdy  = rdy;
        v.wr   = wr;
        v.wl   = wl;
        v.reps = reps;
        v.exp  = {st, vl, ed, rdb};
        return v;
    endfunction

    task automatic check_front();
        sb_t         e;
        logic [10:0] got;
        got = {stall, in_valid, in_data, ready_db};
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty (cycle %0d): got %h, no expectation queued", cyc, got);
        end else begin
            e = sb_q.pop_front();
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got stall=%b in_valid=%b in_data=%h ready_db=%b, expected stall=%b in_valid=%b in_data=%h ready_db=%b",
                         e.name, e.cyc, got[10], got[9], got[8:1], got[0],
                         e.exp[10], e.exp[9], e.exp[8:1], e.exp[0]);
            end
        end
    endtask

    task automatic apply(vec_t v);
        sb_t e;
        for (int k = 0; k < v.reps; k++) begin
            @(posedge clk);
            #1;
            reset      = v.rst;
            sw_data    = v.data;
            sw_ready   = v.rdy;
            wait_req   = v.wr;
            wait_level = v.wl;
            e.name = v.name;
            e.cyc  = cyc;
            e.exp  = v.exp;
            sb_q.push_back(e);
            @(negedge clk);
            check_front();
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        sw_data    = 8'h00;
        sw_ready   = 1'b0;
        wait_req   = 1'b0;
        wait_level = 1'b0;
        repeat (2) @(posedge clk);

        // reset state and idle
        vecs.push_back(mk("reset",       1'b1, 8'h00, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk("idle",        1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 8'h00, 1'b0));
        // wait-high with capture: ready_db at cycle 6, grant at cycle 7
        vecs.push_back(mk("wh_sync",     1'b0, 8'hA5, 1'b1, 1'b1, 1'b1,  6, 1'b1, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk("wh_rdb",      1'b0, 8'hA5, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b0, 8'h00, 1'b1));
        vecs.push_back(mk("wh_grant",    1'b0, 8'hA5, 1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1, 8'hA5, 1'b1));
        vecs.push_back(mk("wh_done",     1'b0, 8'hA5, 1'b1, 1'b0, 1'b0,  2, 1'b0, 1'b0, 8'hA5, 1'b1));
        // wait-low: 3-cycle glitch rejected, sustained low grants without capture
        vecs.push_back(mk("wl_high",     1'b0, 8'h5A, 1'b1, 1'b1, 1'b0,  2, 1'b1, 1'b0, 8'hA5, 1'b1));
        vecs.push_back(mk("wl_glitch",   1'b0, 8'h5A, 1'b0, 1'b1, 1'b0,  3, 1'b1, 1'b0, 8'hA5, 1'b1));
        vecs.push_back(mk("wl_recover",  1'b0, 8'h5A, 1'b1, 1'b1, 1'b0,  4, 1'b1, 1'b0, 8'hA5, 1'b1));
        vecs.push_back(mk("wl_low",      1'b0, 8'h5A, 1'b0, 1'b1, 1'b0,  6, 1'b1, 1'b0, 8'hA5, 1'b1));
        vecs.push_back(mk("wl_rdb",      1'b0, 8'h5A, 1'b0, 1'b1, 1'b0,  1, 1'b1, 1'b0, 8'hA5, 1'b0));
        vecs.push_back(mk("wl_grant",    1'b0, 8'h5A, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1, 8'hA5, 1'b0));
        vecs.push_back(mk("wl_done",     1'b0, 8'h5A, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'hA5, 1'b0));
        // level already satisfied: exactly two stall cycles
        vecs.push_back(mk("pre_high",    1'b0, 8'h5A, 1'b1, 1'b0, 1'b0,  6, 1'b0, 1'b0, 8'hA5, 1'b0));
        vecs.push_back(mk("pre_rdb",     1'b0, 8'h5A, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'hA5, 1'b1));
        vecs.push_back(mk("fast_idle",   1'b0, 8'hC3, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b0, 8'hA5, 1'b1));
        vecs.push_back(mk("fast_wait",   1'b0, 8'hC3, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b0, 8'hA5, 1'b1));
        vecs.push_back(mk("fast_grant",  1'b0, 8'hC3, 1'b1, 1'b0, 1'b1,  1, 1'b0, 1'b1, 8'hC3, 1'b1));
        vecs.push_back(mk("fast_done",   1'b0, 8'hC3, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'hC3, 1'b1));
        // reset in WAIT while toggling and while a grant would otherwise fire
        vecs.push_back(mk("rst_wait0",   1'b0, 8'hC3, 1'b0, 1'b1, 1'b0,  1, 1'b1, 1'b0, 8'hC3, 1'b1));
        vecs.push_back(mk("rst_wait1",   1'b0, 8'hC3, 1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b0, 8'hC3, 1'b1));
        vecs.push_back(mk("rst_wait2",   1'b0, 8'hC3, 1'b0, 1'b1, 1'b0,  1, 1'b1, 1'b0, 8'hC3, 1'b1));
        vecs.push_back(mk("rst_wait3",   1'b0, 8'hC3, 1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b0, 8'hC3, 1'b1));
        vecs.push_back(mk("rst_assert",  1'b1, 8'hC3, 1'b0, 1'b1, 1'b1,  1, 1'b1, 1'b0, 8'hC3, 1'b1));
        vecs.push_back(mk("rst_after",   1'b0, 8'hC3, 1'b0, 1'b0, 1'b0,  3, 1'b0, 1'b0, 8'h00, 1'b0));
        // back-to-back high/low/high with wait_req held
        vecs.push_back(mk("hs1_sync",    1'b0, 8'h12, 1'b1, 1'b1, 1'b1,  6, 1'b1, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk("hs1_rdb",     1'b0, 8'h12, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b0, 8'h00, 1'b1));
        vecs.push_back(mk("hs1_grant",   1'b0, 8'h12, 1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1, 8'h12, 1'b1));
        vecs.push_back(mk("hs2_sync",    1'b0, 8'h34, 1'b0, 1'b1, 1'b0,  6, 1'b1, 1'b0, 8'h12, 1'b1));
        vecs.push_back(mk("hs2_rdb",     1'b0, 8'h34, 1'b0, 1'b1, 1'b0,  1, 1'b1, 1'b0, 8'h12, 1'b0));
        vecs.push_back(mk("hs2_grant",   1'b0, 8'h34, 1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 8'h12, 1'b0));
        vecs.push_back(mk("hs3_sync",    1'b0, 8'h34, 1'b1, 1'b1, 1'b1,  6, 1'b1, 1'b0, 8'h12, 1'b0));
        vecs.push_back(mk("hs3_rdb",     1'b0, 8'h34, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b0, 8'h12, 1'b1));
        vecs.push_back(mk("hs3_grant",   1'b0, 8'h34, 1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1, 8'h34, 1'b1));
        vecs.push_back(mk("hs_done",     1'b0, 8'h34, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'h34, 1'b1));

        foreach (vecs[i]) begin
            apply(vecs[i]);
        end

        // hand-written corner: reset arriving during GRANT clears the fresh capture
        apply(mk("gr_idle",  1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 8'h34, 1'b1));
        apply(mk("gr_wait",  1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 8'h34, 1'b1));
        apply(mk("gr_reset", 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1, 8'h77, 1'b1));
        apply(mk("gr_after", 1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00, 1'b0));

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
